// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and defaults for the UART frame sequencer
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    CSUM
  } frame_state_t;

  typedef enum logic [1:0] {
    ISSUE,
    HOLD,
    WAIT
  } byte_step_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE  = 8'hFF;
  localparam int         DEFAULT_SYNC_COUNT = 4;

  // Payload bytes equal to the sync value are nudged down so the header stays unique.
  function automatic logic [7:0] clamp_payload(input logic [7:0] b, input logic [7:0] sync_byte);
    return (b == sync_byte) ? (sync_byte - 8'd1) : b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word fall-through byte FIFO with async active-low reset
module byte_fifo #(
  parameter int DEPTH = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a byte.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_sequencer.sv
// rtl/uart_frame_sequencer.sv - frames buffered payload bytes (sync, length, payload, checksum)
// and paces them into uart_transmit with the trigger/busy handshake.
module uart_frame_sequencer
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 420,
  parameter int         FIFO_DEPTH  = 512,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         SYNC_COUNT  = DEFAULT_SYNC_COUNT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic       byte_ready_out,
  input  logic       frame_start_in,
  input  logic       enable_in,
  input  logic       tx_busy_in,
  output logic [7:0] tx_byte_out,
  output logic       tx_trigger_out,
  output logic       frame_active_out,
  output logic       frame_done_out,
  output logic       frame_drop_out
);

  localparam int            PW       = $clog2(PAYLOAD_LEN + 1);
  localparam int            HW       = $clog2(SYNC_COUNT + 1);
  localparam logic [15:0]   LEN16    = 16'(PAYLOAD_LEN);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_LEN - 1);
  localparam logic [PW-1:0] PAY_ONE  = PW'(1);
  localparam logic [HW-1:0] HDR_LAST = HW'(SYNC_COUNT - 1);
  localparam logic [HW-1:0] HDR_MAX  = HW'(SYNC_COUNT);
  localparam logic [HW-1:0] HDR_ONE  = HW'(1);

  frame_state_t  state_q, state_d;
  byte_step_t    step_q, step_d;
  logic [HW-1:0] hdr_cnt_q;
  logic [PW-1:0] pay_cnt_q;
  logic [7:0]    csum_q;
  logic [7:0]    tx_byte_q;
  logic          done_q;
  logic          drop_q;

  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  logic       issue;
  logic       advance;
  logic       accept;
  logic       byte_avail;
  logic [7:0] cur_byte;

  // Ready is held low while reset is asserted and rises once it is released.
  assign byte_ready_out = rst_in && !fifo_full;
  assign fifo_push      = byte_valid_in && byte_ready_out;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (byte_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      step_q  <= ISSUE;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    issue      = 1'b0;
    advance    = 1'b0;
    accept     = 1'b0;
    fifo_pop   = 1'b0;
    byte_avail = 1'b1;
    cur_byte   = SYNC_BYTE;

    case (state_q)
      LEN_HI:  cur_byte = LEN16[15:8];
      LEN_LO:  cur_byte = LEN16[7:0];
      PAYLOAD: begin
        cur_byte   = clamp_payload(fifo_dout, SYNC_BYTE);
        byte_avail = !fifo_empty;
      end
      CSUM:    cur_byte = csum_q;
      default: cur_byte = SYNC_BYTE;
    endcase

    if (state_q == IDLE) begin
      if (frame_start_in) begin
        accept  = 1'b1;
        state_d = SYNC;
        step_d  = ISSUE;
      end
    end else begin
      case (step_q)
        ISSUE: begin
          if (enable_in && !tx_busy_in && byte_avail) begin
            issue    = 1'b1;
            fifo_pop = (state_q == PAYLOAD);
            step_d   = HOLD;
          end
        end
        HOLD: step_d = WAIT;
        WAIT: begin
          if (!tx_busy_in) begin
            advance = 1'b1;
            step_d  = ISSUE;
            case (state_q)
              SYNC:    if (hdr_cnt_q == HDR_LAST) state_d = LEN_HI;
              LEN_HI:  state_d = LEN_LO;
              LEN_LO:  state_d = PAYLOAD;
              PAYLOAD: if (pay_cnt_q == PAY_LAST) state_d = CSUM;
              CSUM:    state_d = IDLE;
              default: state_d = IDLE;
            endcase
          end
        end
        default: step_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      csum_q    <= '0;
      tx_byte_q <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if (accept) begin
        hdr_cnt_q <= '0;
        pay_cnt_q <= '0;
        csum_q    <= '0;
      end else begin
        if (issue && state_q == PAYLOAD) begin
          csum_q <= csum_q + cur_byte;
        end
        if (advance && state_q == SYNC && hdr_cnt_q != HDR_MAX) begin
          hdr_cnt_q <= hdr_cnt_q + HDR_ONE;
        end
        if (advance && state_q == PAYLOAD) begin
          pay_cnt_q <= pay_cnt_q + PAY_ONE;
        end
      end
      if (issue) begin
        tx_byte_q <= cur_byte;
      end
      done_q <= advance && (state_q == CSUM);
      drop_q <= frame_start_in && (state_q != IDLE);
    end
  end

  // The issued byte is presented combinationally alongside the trigger, then held.
  assign tx_byte_out      = issue ? cur_byte : tx_byte_q;
  assign tx_trigger_out   = issue;
  assign frame_active_out = (state_q != IDLE);
  assign frame_done_out   = done_q;
  assign frame_drop_out   = drop_q;

endmodule
